router_pkt_tx: RTL and testbench

Packet source for the router 1x3 input port; the transmit end of the interface the router's input register block receives.
- Loads a payload of 1–63 bytes from an upstream byte stream into an internal buffer, accumulating parity.
- Then serializes the packet onto the router input: header {len[5:0], addr[1:0]}, the payload bytes, and the parity byte with pkt_valid low.
- Honours router busy back-pressure and captures the router's err response.

---
 rtl/router_pkg.sv | 26 ++
 rtl/router_pkt_buf.sv | 23 ++
 rtl/router_pkt_tx.sv | 189 ++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and header helpers for the router 1x3 packet source.
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int LEN_W     = 6;
    localparam int DATA_W    = 8;
    localparam int BUF_DEPTH = 1 << LEN_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HDR,
        ST_PLD,
        ST_PAR,
        ST_GAP
    } state_t;

    // Header byte as seen by the router: length in the upper bits, port in the lower two.
    function automatic logic [DATA_W-1:0] make_header(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] addr
    );
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// 64x8 payload buffer: synchronous write, combinational read.
module router_pkt_buf
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [LEN_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LEN_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router 1x3 input-port packet source: buffers a payload, then sends header, payload and parity.
// Optional macro ROUTER_PKT_TX_ERR_INJ_EN enables bit0 corruption of the parity byte via inject_err.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int MAX_ADDR   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    output logic              ready,
    output logic              reject,
    input  logic [DATA_W-1:0] pl_data,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out,
    input  logic              err_in,
    output logic              pkt_err,
    output logic              done,
    input  logic              inject_err
);

    localparam int                GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MAX_ADDR);

    state_t              state_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [LEN_W-1:0]    len_reg;
    logic [LEN_W-1:0]    load_cnt_reg;
    logic [LEN_W-1:0]    idx_reg;
    logic [GAP_W-1:0]    gap_cnt_reg;
    logic [DATA_W-1:0]   parity_reg;
    logic                ready_reg;
    logic                reject_reg;
    logic                pl_ready_reg;
    logic                pkt_valid_reg;
    logic [DATA_W-1:0]   data_out_reg;
    logic                pkt_err_reg;
    logic                done_reg;

    logic                start_bad;
    logic                buf_wr_en;
    logic [LEN_W-1:0]    buf_rd_addr;
    logic [DATA_W-1:0]   buf_rd_data;
    logic [DATA_W-1:0]   par_byte;

    assign start_bad = (len == '0) || (addr > ADDR_MAX);
    assign buf_wr_en = (state_reg == ST_LOAD) && pl_valid && pl_ready_reg;

    // Read one entry ahead so the next payload byte is ready when the current one transfers.
    assign buf_rd_addr = (state_reg == ST_HDR) ? '0 : idx_reg + LEN_W'(1);

    router_pkt_buf u_buf (
        .clk     (clk),
        .wr_en   (buf_wr_en),
        .wr_addr (load_cnt_reg),
        .wr_data (pl_data),
        .rd_addr (buf_rd_addr),
        .rd_data (buf_rd_data)
    );

`ifdef ROUTER_PKT_TX_ERR_INJ_EN
    logic inj_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && ready_reg && start && !start_bad) begin
            inj_reg <= inject_err;
        end
    end

    assign par_byte = parity_reg ^ {{(DATA_W-1){1'b0}}, inj_reg};
`else
    logic unused_inject_err;
    assign unused_inject_err = inject_err;
    assign par_byte          = parity_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            len_reg       <= '0;
            load_cnt_reg  <= '0;
            idx_reg       <= '0;
            gap_cnt_reg   <= '0;
            parity_reg    <= '0;
            ready_reg     <= 1'b0;
            reject_reg    <= 1'b0;
            pl_ready_reg  <= 1'b0;
            pkt_valid_reg <= 1'b0;
            data_out_reg  <= '0;
            pkt_err_reg   <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg   <= 1'b0;
            reject_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    ready_reg <= 1'b1;
                    if (start && ready_reg) begin
                        if (start_bad) begin
                            reject_reg <= 1'b1;
                        end else begin
                            addr_reg     <= addr;
                            len_reg      <= len;
                            pkt_err_reg  <= 1'b0;
                            parity_reg   <= make_header(len, addr);
                            load_cnt_reg <= '0;
                            idx_reg      <= '0;
                            ready_reg    <= 1'b0;
                            pl_ready_reg <= 1'b1;
                            state_reg    <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (pl_valid && pl_ready_reg) begin
                        parity_reg   <= parity_reg ^ pl_data;
                        load_cnt_reg <= load_cnt_reg + LEN_W'(1);
                        if (load_cnt_reg == len_reg - LEN_W'(1)) begin
                            pl_ready_reg <= 1'b0;
                            state_reg    <= ST_HDR;
                        end
                    end
                end
                ST_HDR: begin
                    // First HDR cycle presents the header; it transfers on a later non-busy cycle.
                    if (!pkt_valid_reg) begin
                        pkt_valid_reg <= 1'b1;
                        data_out_reg  <= make_header(len_reg, addr_reg);
                    end else if (!busy) begin
                        data_out_reg <= buf_rd_data;
                        idx_reg      <= '0;
                        state_reg    <= ST_PLD;
                    end
                end
                ST_PLD: begin
                    if (!busy) begin
                        if (idx_reg == len_reg - LEN_W'(1)) begin
                            pkt_valid_reg <= 1'b0;
                            data_out_reg  <= par_byte;
                            state_reg     <= ST_PAR;
                        end else begin
                            idx_reg      <= idx_reg + LEN_W'(1);
                            data_out_reg <= buf_rd_data;
                        end
                    end
                end
                ST_PAR: begin
                    if (!busy) begin
                        data_out_reg <= '0;
                        gap_cnt_reg  <= '0;
                        state_reg    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    pkt_err_reg <= pkt_err_reg | err_in;
                    if (gap_cnt_reg == GAP_LAST) begin
                        done_reg  <= 1'b1;
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready     = ready_reg;
    assign reject    = reject_reg;
    assign pl_ready  = pl_ready_reg;
    assign pkt_valid = pkt_valid_reg;
    assign data_out  = data_out_reg;
    assign pkt_err   = pkt_err_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: random payloads against a packet-level reference model.
module tb_router_pkt_tx;

    localparam int GAP_CYCLES  = 2;
    localparam int MAX_ADDR    = 2;
    localparam int CYCLE_LIMIT = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] addr;
    logic [5:0] len;
    logic       ready;
    logic       reject;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       err_in;
    logic       pkt_err;
    logic       done;
    logic       inject_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    router_pkt_tx #(
        .GAP_CYCLES (GAP_CYCLES),
        .MAX_ADDR   (MAX_ADDR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .addr       (addr),
        .len        (len),
        .ready      (ready),
        .reject     (reject),
        .pl_data    (pl_data),
        .pl_valid   (pl_valid),
        .pl_ready   (pl_ready),
        .busy       (busy),
        .pkt_valid  (pkt_valid),
        .data_out   (data_out),
        .err_in     (err_in),
        .pkt_err    (pkt_err),
        .done       (done),
        .inject_err (inject_err)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Sends one packet, acting as upstream source and as the router (busy, err_in) at once.
    task automatic run_packet(
        input  logic [1:0] a,
        input  logic [5:0] n,
        input  bit         seq_data,
        input  int         pv_pct,
        input  int         hdr_busy,
        input  int         stall_idx,
        input  int         stall_cnt,
        input  int         busy_pct,
        input  bit         inj,
        input  bit         force_err,
        input  int         rst_at,
        output int         cycles
    );
        logic [7:0] payload[$];
        logic [7:0] exp_bytes[$];
        logic [7:0] hdr, exp_par, rx_xor, got_par, hold_data;
        int  k, nx, cyc, busy_n, ld_stall, hdr_left, stall_left, first_valid;
        bit  par_seen, done_seen, held, aborted, reset_hit, exp_err;

        hdr     = {n, a};
        exp_par = hdr;
        for (int i = 0; i < int'(n); i++) begin
            payload.push_back(seq_data ? 8'(i + 1) : 8'($urandom));
            exp_par ^= payload[i];
        end
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
        if (inj) exp_par ^= 8'h01;
        exp_err = force_err || inj;
`else
        exp_err = force_err;
`endif
        exp_bytes.push_back(hdr);
        foreach (payload[i]) exp_bytes.push_back(payload[i]);

        k = 0; nx = 0; cyc = 0; busy_n = 0; ld_stall = 0; first_valid = 0;
        hdr_left = hdr_busy; stall_left = stall_cnt;
        rx_xor = 8'h00; got_par = 8'h00; hold_data = 8'h00;
        par_seen = 0; done_seen = 0; held = 0; aborted = 0; reset_hit = 0;

        check("ready_before_start", ready, 1);
        start = 1'b1; addr = a; len = n; inject_err = inj;

        while (!done_seen && !aborted && cyc < CYCLE_LIMIT) begin
            @(negedge clk);
            cyc++;
            busy = 1'b0; pl_valid = 1'b0; err_in = 1'b0;
            if (cyc == 1) begin
                check("ready_low_after_accept", ready, 0);
                check("pkt_err_cleared", pkt_err, 0);
            end
            check("no_reject_in_packet", reject, 0);
            if (held) check("hold_stable", data_out, hold_data);
            held = 0;
            if (pkt_valid && first_valid == 0) first_valid = cyc;

            if (done) begin
                done_seen = 1;
                start     = 1'b0;
            end else if (rst_at >= 0 && pkt_valid && nx == rst_at + 1) begin
                start = 1'b0;
                rst   = 1'b1;
                #1;
                check("rst_valid_drop", pkt_valid, 0);
                check("rst_ready_low", ready, 0);
                repeat (3) begin
                    @(negedge clk);
                    check("rst_no_done", done, 0);
                    check("rst_no_valid", pkt_valid, 0);
                end
                rst       = 1'b0;
                aborted   = 1;
                reset_hit = 1;
            end else begin
                // starts while a packet is in flight must be ignored
                start      = 1'($urandom);
                addr       = 2'($urandom);
                len        = 6'($urandom);
                inject_err = 1'($urandom);

                if (pkt_valid) begin
                    if (nx == 0 && hdr_left > 0) begin
                        busy = 1'b1; hdr_left--;
                    end else if (nx == stall_idx + 1 && stall_left > 0) begin
                        busy = 1'b1; stall_left--;
                    end else begin
                        busy = ($urandom_range(99) < busy_pct);
                    end
                    if (busy) begin
                        busy_n++; held = 1; hold_data = data_out;
                    end else if (nx <= int'(n)) begin
                        if (nx == 0) check("header", data_out, exp_bytes[nx]);
                        else         check("payload", data_out, exp_bytes[nx]);
                        rx_xor ^= data_out;
                        nx++;
                    end else begin
                        check("extra_byte", nx, n + 1);
                        aborted = 1;
                    end
                end else if (nx > 0 && nx <= int'(n)) begin
                    check("valid_drop", pkt_valid, 1);
                    aborted = 1;
                end else if (nx == int'(n) + 1 && !par_seen) begin
                    busy = ($urandom_range(99) < busy_pct);
                    if (busy) begin
                        busy_n++; held = 1; hold_data = data_out;
                    end else begin
                        check("parity", data_out, exp_par);
                        got_par  = data_out;
                        par_seen = 1;
                    end
                end else if (par_seen) begin
                    check("gap_data", data_out, 0);
                    err_in = force_err || (got_par != rx_xor);
                end

                if (pl_ready) begin
                    check("no_tx_in_load", pkt_valid, 0);
                    if (k < int'(n)) begin
                        pl_valid = ($urandom_range(99) < pv_pct);
                        pl_data  = payload[k];
                        if (pl_valid) k++;
                        else ld_stall++;
                    end else begin
                        check("pl_ready_extra", pl_ready, 0);
                        aborted = 1;
                    end
                end else begin
                    pl_valid = 1'($urandom);
                    pl_data  = 8'($urandom);
                end
            end
        end

        busy = 1'b0; pl_valid = 1'b0; err_in = 1'b0; start = 1'b0; inject_err = 1'b0;
        cycles = cyc;
        if (reset_hit) begin
            $display("pkt addr=%0d len=%0d aborted by reset after %0d bytes", a, n, nx);
            return;
        end
        check("done_seen", done_seen, 1);
        check("tx_count", nx, n + 1);
        check("parity_seen", par_seen, 1);
        check("duration", cyc, 2 * n + 4 + GAP_CYCLES + busy_n + ld_stall);
        if (pv_pct == 100) check("hdr_latency", first_valid, n + 2);
        check("pkt_err", pkt_err, exp_err);
        @(negedge clk);
        check("done_pulse_end", done, 0);
        check("pkt_err_hold", pkt_err, exp_err);
        check("ready_after_done", ready, 1);
        $display("pkt addr=%0d len=%0d cycles=%0d busy=%0d stalls=%0d parity=0x%02h pkt_err=%0d",
                 a, n, cyc, busy_n, ld_stall, got_par, pkt_err);
    endtask

    task automatic try_reject(input logic [1:0] a, input logic [5:0] n, input bit exp_pkt_err);
        start = 1'b1; addr = a; len = n;
        @(negedge clk);
        check("reject_pulse", reject, 1);
        check("reject_ready", ready, 1);
        check("reject_no_valid", pkt_valid, 0);
        check("reject_keeps_pkt_err", pkt_err, exp_pkt_err);
        start = 1'b0;
        @(negedge clk);
        check("reject_one_cycle", reject, 0);
        check("reject_no_load", pl_ready, 0);
        check("reject_still_no_valid", pkt_valid, 0);
        $display("reject addr=%0d len=%0d reject_seen ready=%0d", a, n, ready);
    endtask

    initial begin
        int cyc_plain, cyc_busy, dummy;
        rst = 1'b1; start = 1'b0; addr = '0; len = '0; pl_data = '0; pl_valid = 1'b0;
        busy = 1'b0; err_in = 1'b0; inject_err = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_pl_ready", pl_ready, 0);
        check("rst_done", done, 0);
        check("rst_reject", reject, 0);
        check("rst_pkt_err", pkt_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_post_reset", ready, 1);

        // addr=2 len=10 bytes 1..10: header 0x2A, parity 0x21
        run_packet(2'd2, 6'd10, 1, 100, 0, 0, 0, 0, 0, 0, -1, cyc_plain);
        check("basic_duration", cyc_plain, 26);

        // same packet, 3 busy cycles on the header and 1 on payload byte 5
        run_packet(2'd2, 6'd10, 1, 100, 3, 5, 1, 0, 0, 0, -1, cyc_busy);
        check("busy_extra_cycles", cyc_busy - cyc_plain, 4);

        // router reports an error during the gap; pkt_err must survive rejected starts
        run_packet(2'd1, 6'd5, 0, 100, 0, 0, 0, 0, 0, 1, -1, dummy);
        try_reject(2'd1, 6'd0, 1);
        try_reject(2'd3, 6'd7, 1);

        // maximum length with a 50% upstream duty cycle
        run_packet(2'd2, 6'd63, 0, 50, 0, 0, 0, 0, 0, 0, -1, dummy);

        // reset in the middle of the payload, then a clean packet
        run_packet(2'd0, 6'd8, 0, 100, 0, 0, 0, 0, 0, 0, 4, dummy);
        @(negedge clk);
        check("ready_after_mid_rst", ready, 1);
        check("valid_after_mid_rst", pkt_valid, 0);
        check("done_after_mid_rst", done, 0);
        run_packet(2'd0, 6'd8, 0, 100, 0, 0, 0, 0, 0, 0, -1, dummy);

        // parity corruption request; only honoured when the feature is built in
        run_packet(2'd1, 6'd12, 0, 100, 0, 0, 0, 0, 1, 0, -1, dummy);
        run_packet(2'd0, 6'd1, 0, 100, 0, 0, 0, 0, 0, 0, -1, dummy);

        for (int t = 0; t < 6; t++) begin
            run_packet(2'($urandom_range(MAX_ADDR)), 6'($urandom_range(63, 1)), 0, 70,
                       0, 0, 0, 25, 0, 0, -1, dummy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
